// File: rtl/axis_pattern_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_pattern_streamer_pkg
// Purpose  : Shared definitions for the AXI4-Stream test-pattern streamer:
//            pattern select codes, FSM state encodings and the pixel pack
//            helper that places 24-bit RGB into a 32-bit {8'h00,R,G,B} slot.
// Revision : 1.0 - initial release
// ============================================================================
package axis_pattern_streamer_pkg;

    // Test pattern codes carried on pattern_sel
    localparam logic [1:0] c_pat_gradient = 2'd0;
    localparam logic [1:0] c_pat_bars     = 2'd1;
    localparam logic [1:0] c_pat_checker  = 2'd2;
    localparam logic [1:0] c_pat_xor      = 2'd3;

    // Streamer FSM state encodings
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_load   = 2'd1;
    localparam logic [1:0] c_st_stream = 2'd2;

    // Bits per pixel slot on the stream
    localparam int c_pix_w = 32;

    // Pack a 24-bit {R,G,B} value into one 32-bit pixel slot
    function automatic logic [31:0] pack_pixel(input logic [23:0] rgb);
        return {8'h00, rgb};
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_pattern_streamer_pattern_pixel.sv
`default_nettype none
// ============================================================================
// Module   : axis_pattern_streamer_pattern_pixel
// Purpose  : Combinational colour generator for one pixel.
// Ports    : i_px    - pixel column (0 .. X_SIZE-1)
//            i_y     - low 8 bits of the line number
//            i_frame - low 8 bits of the frame counter
//            i_sel   - pattern code
//            o_rgb   - {R,G,B}, 8 bits each
// Revision : 1.0 - initial release
// ============================================================================
module axis_pattern_streamer_pattern_pixel
    import axis_pattern_streamer_pkg::*;
#(
    parameter int X_SIZE = 640,
    parameter int XW     = 10
) (
    input  logic [XW-1:0] i_px,
    input  logic [7:0]    i_y,
    input  logic [7:0]    i_frame,
    input  logic [1:0]    i_sel,
    output logic [23:0]   o_rgb
);

    // Line width at the widened precision used for the bar index divide
    localparam logic [XW+2:0] c_xsize = (XW+3)'(X_SIZE);

    logic [XW+2:0] w_scaled;
    logic [2:0]    w_bar;
    logic [7:0]    w_px8;
    logic          w_px5;
    logic [7:0]    w_chk;
    logic [7:0]    w_xor;

    // px*8 computed three bits wider so it cannot overflow before the divide
    assign w_scaled = {i_px, 3'b000};
    assign w_bar    = 3'(w_scaled / c_xsize);
    assign w_px8    = 8'(i_px);

    // Narrow lines never reach column 32, so bit 5 of px is then always 0
    if (XW > 5) begin : g_px5_wide
        assign w_px5 = i_px[5];
    end else begin : g_px5_narrow
        assign w_px5 = 1'b0;
    end

    assign w_chk = (w_px5 ^ i_y[5]) ? 8'hFF : 8'h00;
    assign w_xor = w_px8 ^ i_y;

    always_comb begin
        o_rgb = 24'h000000;
        case (i_sel)
            c_pat_gradient: o_rgb = {w_px8, i_y, i_frame};
            c_pat_bars:     o_rgb = {{8{w_bar[2]}}, {8{w_bar[1]}}, {8{w_bar[0]}}};
            c_pat_checker:  o_rgb = {w_chk, w_chk, w_chk};
            c_pat_xor:      o_rgb = {w_xor, w_xor, w_xor};
            default:        o_rgb = 24'h000000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axis_pattern_streamer.sv
`default_nettype none
// ============================================================================
// Module   : axis_pattern_streamer
// Purpose  : Emits AXI4-Stream video frames of X_SIZE x Y_SIZE pixels,
//            PIX_PER_BEAT pixels per beat, with tready backpressure, a
//            selectable test pattern, tuser on the first beat of a frame and
//            tlast per line (LAST_MODE 0) or per frame (LAST_MODE 1).
// Ports    : out_stream_aclk   - clock
//            periph_reset      - synchronous active-high reset
//            enable            - frames stream while high
//            pattern_sel       - 0 gradient, 1 bars, 2 checker, 3 x^y
//            out_stream_t*     - AXI4-Stream master (tdata/tkeep/tvalid/
//                                tready/tuser/tlast)
//            frame_done        - 1-cycle pulse after the last beat is taken
//            frame_count       - completed frames, wraps at 16 bits
// Revision : 1.0 - initial release
// ============================================================================
module axis_pattern_streamer
    import axis_pattern_streamer_pkg::*;
#(
    parameter int X_SIZE       = 640,
    parameter int Y_SIZE       = 480,
    parameter int PIX_PER_BEAT = 1,
    parameter int LAST_MODE    = 0,
    localparam int TDATA_W     = 32 * PIX_PER_BEAT
) (
    input  logic                 out_stream_aclk,
    input  logic                 periph_reset,
    input  logic                 enable,
    input  logic [1:0]           pattern_sel,
    output logic [TDATA_W-1:0]   out_stream_tdata,
    output logic [TDATA_W/8-1:0] out_stream_tkeep,
    output logic                 out_stream_tvalid,
    input  logic                 out_stream_tready,
    output logic                 out_stream_tuser,
    output logic                 out_stream_tlast,
    output logic                 frame_done,
    output logic [15:0]          frame_count
);

    if ((X_SIZE % PIX_PER_BEAT) != 0) begin : g_bad_xsize
        $error("axis_pattern_streamer: X_SIZE must be a multiple of PIX_PER_BEAT");
    end
    if (!(PIX_PER_BEAT == 1 || PIX_PER_BEAT == 2 || PIX_PER_BEAT == 4)) begin : g_bad_ppb
        $error("axis_pattern_streamer: PIX_PER_BEAT must be 1, 2 or 4");
    end

    localparam int c_xw = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int c_yw = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

    localparam logic [c_xw-1:0] c_x_last = c_xw'(X_SIZE - PIX_PER_BEAT);
    localparam logic [c_xw-1:0] c_x_step = c_xw'(PIX_PER_BEAT);
    localparam logic [c_yw-1:0] c_y_last = c_yw'(Y_SIZE - 1);

    logic [1:0]         r_state;
    logic [c_xw-1:0]    r_x;
    logic [c_yw-1:0]    r_y;
    logic [1:0]         r_sel;
    logic [TDATA_W-1:0] r_tdata;
    logic               r_tvalid;
    logic               r_tuser;
    logic               r_tlast;
    logic               r_frame_done;
    logic [15:0]        r_frame_count;

    logic               w_handshake;
    logic               w_line_end;
    logic               w_frame_end;
    logic [c_xw-1:0]    w_step_x;
    logic [c_yw-1:0]    w_step_y;
    logic [c_xw-1:0]    w_gen_x;
    logic [c_yw-1:0]    w_gen_y;
    logic [1:0]         w_gen_sel;
    logic               w_gen_user;
    logic               w_gen_last;
    logic [TDATA_W-1:0] w_gen_data;
    logic [23:0]        w_rgb [PIX_PER_BEAT];

    assign w_handshake = r_tvalid & out_stream_tready;
    assign w_line_end  = (r_x == c_x_last);
    assign w_frame_end = w_line_end && (r_y == c_y_last);

    // Coordinates of the beat following the one currently presented
    assign w_step_x = w_line_end ? '0 : r_x + c_x_step;
    assign w_step_y = w_line_end ? ((r_y == c_y_last) ? '0 : r_y + c_yw'(1)) : r_y;

    // The generator is aimed at (0,0) with the live pattern_sel while loading,
    // otherwise at the next beat with the pattern latched for this frame.
    assign w_gen_x   = (r_state == c_st_load) ? '0 : w_step_x;
    assign w_gen_y   = (r_state == c_st_load) ? '0 : w_step_y;
    assign w_gen_sel = (r_state == c_st_load) ? pattern_sel : r_sel;

    assign w_gen_user = (w_gen_x == '0) && (w_gen_y == '0);
    assign w_gen_last = (w_gen_x == c_x_last) && ((LAST_MODE == 0) || (w_gen_y == c_y_last));

    for (genvar gi = 0; gi < PIX_PER_BEAT; gi++) begin : g_pix
        logic [c_xw-1:0] w_px;
        assign w_px = w_gen_x + c_xw'(gi);

        axis_pattern_streamer_pattern_pixel #(
            .X_SIZE (X_SIZE),
            .XW     (c_xw)
        ) u_pixel (
            .i_px    (w_px),
            .i_y     (8'(w_gen_y)),
            .i_frame (r_frame_count[7:0]),
            .i_sel   (w_gen_sel),
            .o_rgb   (w_rgb[gi])
        );

        // Pixel gi occupies bits [32*gi+31 : 32*gi]
        assign w_gen_data[c_pix_w*gi +: c_pix_w] = pack_pixel(w_rgb[gi]);
    end

    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            r_state       <= c_st_idle;
            r_x           <= '0;
            r_y           <= '0;
            r_sel         <= '0;
            r_tdata       <= '0;
            r_tvalid      <= 1'b0;
            r_tuser       <= 1'b0;
            r_tlast       <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (enable) begin
                        r_state <= c_st_load;
                    end
                end
                c_st_load: begin
                    r_sel    <= pattern_sel;
                    r_x      <= '0;
                    r_y      <= '0;
                    r_tdata  <= w_gen_data;
                    r_tuser  <= w_gen_user;
                    r_tlast  <= w_gen_last;
                    r_tvalid <= 1'b1;
                    r_state  <= c_st_stream;
                end
                c_st_stream: begin
                    if (w_handshake) begin
                        if (w_frame_end) begin
                            // Frame complete; enable only decides whether another follows
                            r_tvalid      <= 1'b0;
                            r_tuser       <= 1'b0;
                            r_tlast       <= 1'b0;
                            r_frame_done  <= 1'b1;
                            r_frame_count <= r_frame_count + 16'd1;
                            r_x           <= '0;
                            r_y           <= '0;
                            r_state       <= enable ? c_st_load : c_st_idle;
                        end else begin
                            r_x     <= w_step_x;
                            r_y     <= w_step_y;
                            r_tdata <= w_gen_data;
                            r_tuser <= w_gen_user;
                            r_tlast <= w_gen_last;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign out_stream_tdata  = r_tdata;
    assign out_stream_tkeep  = '1;
    assign out_stream_tvalid = r_tvalid;
    assign out_stream_tuser  = r_tuser;
    assign out_stream_tlast  = r_tlast;
    assign frame_done        = r_frame_done;
    assign frame_count       = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_pattern_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pattern_streamer
// Purpose  : Self-checking bench for axis_pattern_streamer. Three instances
//            share the stimulus: 8x4/2ppb tlast-per-line, 8x4/2ppb
//            tlast-per-frame, and 16x4/4ppb. A frame-level reference model
//            predicts every presented beat from pixel coordinates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pattern_streamer;

    logic       clk = 1'b0;
    logic       periph_reset;
    logic       enable;
    logic [1:0] pattern_sel;
    logic       tready;

    always #5 clk = ~clk;

    logic [63:0]  d0_tdata, d1_tdata;
    logic [127:0] d2_tdata;
    logic [7:0]   d0_tkeep, d1_tkeep;
    logic [15:0]  d2_tkeep;

    logic [127:0] o_data  [3];
    logic         o_valid [3];
    logic         o_user  [3];
    logic         o_last  [3];
    logic         o_done  [3];
    logic [15:0]  o_count [3];

    assign o_data[0] = {64'd0, d0_tdata};
    assign o_data[1] = {64'd0, d1_tdata};
    assign o_data[2] = d2_tdata;

    axis_pattern_streamer #(.X_SIZE(8), .Y_SIZE(4), .PIX_PER_BEAT(2), .LAST_MODE(0)) dut0 (
        .out_stream_aclk(clk), .periph_reset(periph_reset), .enable(enable),
        .pattern_sel(pattern_sel), .out_stream_tdata(d0_tdata), .out_stream_tkeep(d0_tkeep),
        .out_stream_tvalid(o_valid[0]), .out_stream_tready(tready), .out_stream_tuser(o_user[0]),
        .out_stream_tlast(o_last[0]), .frame_done(o_done[0]), .frame_count(o_count[0]));

    axis_pattern_streamer #(.X_SIZE(8), .Y_SIZE(4), .PIX_PER_BEAT(2), .LAST_MODE(1)) dut1 (
        .out_stream_aclk(clk), .periph_reset(periph_reset), .enable(enable),
        .pattern_sel(pattern_sel), .out_stream_tdata(d1_tdata), .out_stream_tkeep(d1_tkeep),
        .out_stream_tvalid(o_valid[1]), .out_stream_tready(tready), .out_stream_tuser(o_user[1]),
        .out_stream_tlast(o_last[1]), .frame_done(o_done[1]), .frame_count(o_count[1]));

    axis_pattern_streamer #(.X_SIZE(16), .Y_SIZE(4), .PIX_PER_BEAT(4), .LAST_MODE(0)) dut2 (
        .out_stream_aclk(clk), .periph_reset(periph_reset), .enable(enable),
        .pattern_sel(pattern_sel), .out_stream_tdata(d2_tdata), .out_stream_tkeep(d2_tkeep),
        .out_stream_tvalid(o_valid[2]), .out_stream_tready(tready), .out_stream_tuser(o_user[2]),
        .out_stream_tlast(o_last[2]), .frame_done(o_done[2]), .frame_count(o_count[2]));

    // Geometry of each instance
    int cx [3] = '{8, 8, 16};
    int cy [3] = '{4, 4, 4};
    int cp [3] = '{2, 2, 4};
    int cl [3] = '{0, 1, 0};

    // Reference model state per instance
    bit m_active [3] = '{0, 0, 0};
    bit m_gap    [3] = '{0, 0, 0};
    int m_x      [3] = '{0, 0, 0};
    int m_y      [3] = '{0, 0, 0};
    int m_sel    [3] = '{0, 0, 0};
    int m_count  [3] = '{0, 0, 0};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_pixel(input int px, input int y, input int f,
                                              input int sel, input int xs);
        int r, g, b, bar, v;
        r = 0; g = 0; b = 0;
        case (sel)
            0: begin r = px & 255; g = y & 255; b = f & 255; end
            1: begin
                bar = (px * 8) / xs;
                r = (bar & 4) ? 255 : 0;
                g = (bar & 2) ? 255 : 0;
                b = (bar & 1) ? 255 : 0;
            end
            2: begin v = (((px >> 5) ^ (y >> 5)) & 1) ? 255 : 0; r = v; g = v; b = v; end
            default: begin v = (px ^ y) & 255; r = v; g = v; b = v; end
        endcase
        return {8'h00, r[7:0], g[7:0], b[7:0]};
    endfunction

    // Advance the model by the clock edge just passed, then compare the
    // outputs now presented by instance k against the model.
    task automatic model_step(input int k);
        logic [127:0] exp;
        bit           exp_done;
        string        pfx;
        pfx = $sformatf("d%0d", k);
        exp_done = 1'b0;
        if (periph_reset) begin
            m_active[k] = 0; m_gap[k] = 0; m_x[k] = 0; m_y[k] = 0; m_count[k] = 0;
            check({pfx, "_rst_data"}, o_data[k], 128'd0);
            check({pfx, "_rst_ctrl"}, {o_valid[k], o_user[k], o_last[k], o_done[k], o_count[k]}, 128'd0);
        end else begin
            if (m_active[k]) begin
                if (tready) begin
                    if (m_x[k] == cx[k] - cp[k]) begin
                        m_x[k] = 0;
                        if (m_y[k] == cy[k] - 1) begin
                            m_y[k] = 0;
                            m_active[k] = 0;
                            m_gap[k] = enable;
                            m_count[k] = (m_count[k] + 1) & 16'hFFFF;
                            exp_done = 1'b1;
                        end else begin
                            m_y[k]++;
                        end
                    end else begin
                        m_x[k] += cp[k];
                    end
                end
            end else if (m_gap[k]) begin
                m_gap[k] = 0;
                m_active[k] = 1;
                m_sel[k] = int'(pattern_sel);
            end else if (enable) begin
                m_gap[k] = 1;
            end

            check({pfx, "_tvalid"}, o_valid[k], m_active[k]);
            check({pfx, "_frame_done"}, o_done[k], exp_done);
            check({pfx, "_frame_count"}, o_count[k], m_count[k][15:0]);
            if (m_active[k]) begin
                exp = '0;
                for (int i = 0; i < cp[k]; i++)
                    exp[32*i +: 32] = ref_pixel(m_x[k] + i, m_y[k], m_count[k], m_sel[k], cx[k]);
                check({pfx, "_tdata"}, o_data[k], exp);
                check({pfx, "_tuser"}, o_user[k], (m_x[k] == 0) && (m_y[k] == 0));
                check({pfx, "_tlast"}, o_last[k],
                      (m_x[k] == cx[k] - cp[k]) && (cl[k] == 0 || m_y[k] == cy[k] - 1));
                // Hand-derived beats of the first gradient frame
                if (k == 0 && m_count[0] == 0 && m_sel[0] == 0) begin
                    if (m_x[0] == 0 && m_y[0] == 0)
                        check("d0_grad_beat0", o_data[0], {64'd0, 32'h00010000, 32'h00000000});
                    if (m_x[0] == 2 && m_y[0] == 1)
                        check("d0_grad_beat5", o_data[0], {64'd0, 32'h00030100, 32'h00020100});
                end
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) model_step(k);
    end

    // Inputs change 2 time units after the edge, away from sampling
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        periph_reset = 1'b1;
        enable       = 1'b0;
        pattern_sel  = 2'd0;
        tready       = 1'b0;
        repeat (3) tick();
        periph_reset = 1'b0;
        repeat (3) tick();

        // Start-up latency: LOAD on the first edge, first beat on the second
        enable = 1'b1;
        tready = 1'b1;
        @(posedge clk); #1;
        check("lat_load_tvalid", o_valid[0], 1'b0);
        @(posedge clk); #1;
        check("lat_first_tvalid", o_valid[0], 1'b1);
        check("lat_first_tuser", o_user[0], 1'b1);
        #1;
        repeat (40) tick();

        // Random backpressure with occasional pattern changes
        repeat (400) begin
            tready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) pattern_sel = 2'($urandom_range(0, 3));
            tick();
        end

        // Drop enable mid-frame: every frame in flight must complete
        enable = 1'b0;
        repeat (2) tick();
        n = 0;
        while ((o_valid[0] || o_valid[1] || o_valid[2]) && n < 400) begin
            tready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("drain_within_bound", n < 400, 1'b1);
        repeat (5) tick();

        // Reset in the middle of a frame, then restart
        enable = 1'b1;
        repeat (25) begin
            tready = 1'($urandom_range(0, 1));
            tick();
        end
        periph_reset = 1'b1;
        tick();
        periph_reset = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        repeat (300) begin
            tready = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) pattern_sel = 2'($urandom_range(0, 3));
            tick();
        end

        // Mixed random enable toggling, pattern changes and rare resets
        repeat (700) begin
            tready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 19) == 0) pattern_sel = 2'($urandom_range(0, 3));
            periph_reset = ($urandom_range(0, 249) == 0);
            tick();
        end
        periph_reset = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
